// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one 8N1 UART transmitter between
//            NUM_REQ byte-stream requesters. Multi-byte packets hold the
//            line until their last byte. An idle lock is released after
//            LOCK_TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           byte_to_send,
  input  logic                 end_of_byte,
  output logic                 busy,
  output logic                 lock_timeout_err
);

  localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int               CNT_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               last_q, last_d;
  logic [7:0]         byte_q, byte_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               start_q, start_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               eob_q;

  logic               eob_rise;
  logic               any_valid;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   sel_idx;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [PTR_W-1:0]   owner_next;
  logic               capture;

  // Completion is the rising edge of end_of_byte only.
  assign eob_rise   = end_of_byte & ~eob_q;
  assign owner_next = (owner_q == PTR_MAX) ? '0 : owner_q + 1'b1;
  // While locked only the owner is eligible; otherwise the round-robin winner.
  assign sel_idx    = (state_q == S_HOLD) ? owner_q : win_idx;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin : rr_search
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!any_valid && req_valid[idx[PTR_W-1:0]]) begin
        any_valid = 1'b1;
        win_idx   = idx[PTR_W-1:0];
      end
    end
  end

  // Extract valid/data/last of the selected requester and its one-hot code.
  always_comb begin : slice_select
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == sel_idx) begin
        sel_valid     = req_valid[i];
        sel_last      = req_last[i];
        sel_data      = req_data[8*i +: 8];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // A byte is taken only in IDLE/HOLD and never while end_of_byte is high.
  always_comb begin : capture_decode
    capture = 1'b0;
    if (reset && !end_of_byte) begin
      if (state_q == S_IDLE) begin
        capture = any_valid;
      end else if (state_q == S_HOLD) begin
        capture = sel_valid;
      end
    end
  end

  assign req_ready = capture ? sel_onehot : '0;

  // Next-state and registered-output computation.
  always_comb begin : next_state
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    last_d   = last_q;
    byte_d   = byte_q;
    grant_d  = grant_q;
    start_d  = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (capture) begin
          state_d = S_START;
          owner_d = sel_idx;
          last_d  = sel_last;
          byte_d  = sel_data;
          grant_d = sel_onehot;
          start_d = 1'b1;
          cnt_d   = '0;
        end else if (state_q == S_HOLD) begin
          if (cnt_q == CNT_LAST) begin
            // Owner went quiet mid-packet: release the line to the next one.
            err_d    = 1'b1;
            grant_d  = '0;
            rr_ptr_d = owner_next;
            state_d  = S_IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (eob_rise) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = owner_next;
            state_d  = S_IDLE;
          end else begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      last_q   <= 1'b0;
      byte_q   <= '0;
      grant_q  <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      eob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      byte_q   <= byte_d;
      grant_q  <= grant_d;
      start_q  <= start_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      eob_q    <= end_of_byte;
    end
  end

  assign grant            = grant_q;
  assign tx_start         = start_q;
  assign byte_to_send     = byte_q;
  assign lock_timeout_err = err_q;
  assign busy             = (state_q != S_IDLE);

endmodule
`default_nettype wire
